// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - LSU data-port request/grant/rvalid signal bundle
interface data_mem_responder_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port memory slave with programmable grant/response latency
module data_mem_responder #(
    parameter int          DEPTH           = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_DELAY       = 0,
    parameter int          RSP_LATENCY     = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] GNT_CNT_MAX = CW'(GNT_DELAY);
    localparam logic [OW-1:0] OUTST_MAX   = OW'(MAX_OUTSTANDING);

    typedef enum logic {ST_IDLE, ST_WAIT} gnt_state_t;

    gnt_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cur_cnt;
    logic [OW-1:0] outstanding;
    logic          full;
    logic          grant;
    logic          rsp_fire;

    logic [31:0]   word_off;
    logic [AW-1:0] word_idx;
    logic          addr_err;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word;
    logic [31:0]   new_data;

    logic          pipe_vld  [RSP_LATENCY];
    logic [31:0]   pipe_data [RSP_LATENCY];
    logic          pipe_err  [RSP_LATENCY];

    // Address decode; the subtraction wraps for addresses below the base, caught separately
    assign word_off = (bus.data_addr_o - BASE_ADDR) >> 2;
    assign word_idx = word_off[AW-1:0];
    assign addr_err = (bus.data_addr_o < BASE_ADDR) || (word_off >= 32'(DEPTH));

    // Full is judged on the registered count, so a same-cycle retire frees nothing yet
    assign full     = (outstanding == OUTST_MAX);
    assign cur_cnt  = (state == ST_WAIT) ? wait_cnt : '0;
    assign grant    = rst_n && bus.data_req_o && (cur_cnt == GNT_CNT_MAX) && !full;
    assign rsp_fire = pipe_vld[RSP_LATENCY-1];

    assign bus.data_gnt_i = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else if (grant || !bus.data_req_o) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= ST_WAIT;
            wait_cnt <= (cur_cnt == GNT_CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (grant && !rsp_fire) begin
            outstanding <= outstanding + 1'b1;
        end else if (!grant && rsp_fire) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    // RAM is deliberately not reset so granted writes survive a reset pulse
    always_ff @(posedge clk) begin
        if (grant && bus.data_we_o && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_o[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.data_wdata_o[8*b +: 8];
                end
            end
        end
    end

    assign rd_word  = mem[word_idx];
    assign new_data = (bus.data_we_o || addr_err) ? '0 : rd_word;

    // Fixed-latency delay line: one grant per cycle keeps responses ordered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= '0;
                pipe_err[i]  <= 1'b0;
            end
        end else begin
            pipe_vld[0]  <= grant;
            pipe_data[0] <= grant ? new_data : '0;
            pipe_err[0]  <= grant && addr_err;
            for (int i = 1; i < RSP_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_err[i]  <= pipe_err[i-1];
            end
        end
    end

    assign bus.data_rvalid_i = pipe_vld[RSP_LATENCY-1];
    assign bus.data_rdata_i  = pipe_data[RSP_LATENCY-1];
    assign bus.data_err_i    = pipe_err[RSP_LATENCY-1];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - three-configuration bench with queue-based reference model
module tb_data_mem_responder;
    localparam int NI  = 3;
    localparam int DEP = 64;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam logic [31:0] BASE2 = 32'h0000_0000;

    typedef enum logic [1:0] {K_IDLE, K_TXN, K_ABORT} kind_t;
    typedef struct { kind_t kind; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { int due; logic [31:0] data; logic err; } rsp_t;

    logic clk;
    logic rst_n;
    logic [NI-1:0] req, we, gnt, rvalid, err;
    logic [3:0]    be    [NI];
    logic [31:0]   addr  [NI];
    logic [31:0]   wdata [NI];
    logic [31:0]   rdata [NI];

    int          gd_m [NI] = '{0, 2, 0};
    int          rl_m [NI] = '{1, 2, 4};
    int          mx_m [NI] = '{2, 3, 2};
    logic [31:0] base_m [NI] = '{BASE0, BASE1, BASE2};

    txn_t        txq [NI][$];
    txn_t        cur [NI];
    bit          cur_valid [NI];
    rsp_t        rspq [NI][$];
    int          held [NI];
    int          outst [NI];
    logic [31:0] mem_m  [NI][DEP];
    logic [31:0] init_w [NI][DEP];
    int          gnt_log [NI][$];
    int          rv_log  [NI][$];
    logic [31:0] rsp_data [NI][$];
    logic        rsp_err  [NI][$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    data_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE0), .GNT_DELAY(0), .RSP_LATENCY(1), .MAX_OUTSTANDING(2))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE1), .GNT_DELAY(2), .RSP_LATENCY(2), .MAX_OUTSTANDING(3))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    data_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE2), .GNT_DELAY(0), .RSP_LATENCY(4), .MAX_OUTSTANDING(2))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.data_req_o = req[0]; assign bus0.data_we_o = we[0]; assign bus0.data_be_o = be[0];
    assign bus0.data_addr_o = addr[0]; assign bus0.data_wdata_o = wdata[0];
    assign gnt[0] = bus0.data_gnt_i; assign rvalid[0] = bus0.data_rvalid_i;
    assign rdata[0] = bus0.data_rdata_i; assign err[0] = bus0.data_err_i;

    assign bus1.data_req_o = req[1]; assign bus1.data_we_o = we[1]; assign bus1.data_be_o = be[1];
    assign bus1.data_addr_o = addr[1]; assign bus1.data_wdata_o = wdata[1];
    assign gnt[1] = bus1.data_gnt_i; assign rvalid[1] = bus1.data_rvalid_i;
    assign rdata[1] = bus1.data_rdata_i; assign err[1] = bus1.data_err_i;

    assign bus2.data_req_o = req[2]; assign bus2.data_we_o = we[2]; assign bus2.data_be_o = be[2];
    assign bus2.data_addr_o = addr[2]; assign bus2.data_wdata_o = wdata[2];
    assign gnt[2] = bus2.data_gnt_i; assign rvalid[2] = bus2.data_rvalid_i;
    assign rdata[2] = bus2.data_rdata_i; assign err[2] = bus2.data_err_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input kind_t kind, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.kind = kind; t.we = w; t.be = b; t.addr = a; t.wdata = d;
        txq[k].push_back(t);
    endtask

    task automatic clear_logs(input int k);
        gnt_log[k].delete(); rv_log[k].delete(); rsp_data[k].delete(); rsp_err[k].delete();
    endtask

    function automatic bit busy();
        for (int k = 0; k < NI; k++)
            if (cur_valid[k] || txq[k].size() > 0 || rspq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: grant when the request has been held GNT_DELAY cycles and fewer than
    // MAX transactions are pending; each grant schedules its response at cycle+latency.
    task automatic model_step(input int k);
        logic        eg, ev, ee, in_rng;
        logic [31:0] ed;
        int          idx;
        rsp_t        r;
        if (gnt[k]) gnt_log[k].push_back(cyc);
        if (rvalid[k]) begin
            rv_log[k].push_back(cyc); rsp_data[k].push_back(rdata[k]); rsp_err[k].push_back(err[k]);
        end
        eg = 1'b0; ev = 1'b0; ee = 1'b0; ed = '0;
        if (!rst_n) begin
            rspq[k].delete(); outst[k] = 0; held[k] = 0;
        end else begin
            eg = req[k] && (held[k] >= gd_m[k]) && (outst[k] < mx_m[k]);
            ev = (rspq[k].size() > 0) && (rspq[k][0].due == cyc);
            if (ev) begin ed = rspq[k][0].data; ee = rspq[k][0].err; end
        end
        check($sformatf("gnt%0d@%0d", k, cyc), gnt[k], eg);
        check($sformatf("rvalid%0d@%0d", k, cyc), rvalid[k], ev);
        check($sformatf("rdata%0d@%0d", k, cyc), rdata[k], ed);
        check($sformatf("err%0d@%0d", k, cyc), err[k], ee);
        if (rst_n) begin
            if (ev) begin r = rspq[k].pop_front(); outst[k]--; end
            if (eg) begin
                in_rng = (cur[k].addr >= base_m[k]) && (((cur[k].addr - base_m[k]) / 4) < DEP);
                idx = in_rng ? int'((cur[k].addr - base_m[k]) / 4) : 0;
                r.due = cyc + rl_m[k]; r.err = !in_rng; r.data = '0;
                if (in_rng && cur[k].we) begin
                    for (int b = 0; b < 4; b++)
                        if (cur[k].be[b]) mem_m[k][idx][8*b +: 8] = cur[k].wdata[8*b +: 8];
                end else if (in_rng) begin
                    r.data = mem_m[k][idx];
                end
                rspq[k].push_back(r);
                outst[k]++; held[k] = 0; cur_valid[k] = 1'b0;
            end else begin
                held[k] = req[k] ? held[k] + 1 : 0;
            end
        end
        if (cur_valid[k] && cur[k].kind != K_TXN) cur_valid[k] = 1'b0;
    endtask

    task automatic cycle();
        for (int k = 0; k < NI; k++) begin
            if (!cur_valid[k] && txq[k].size() > 0) begin
                cur[k] = txq[k].pop_front(); cur_valid[k] = 1'b1;
            end
            req[k]   = cur_valid[k] && (cur[k].kind != K_IDLE);
            we[k]    = req[k] ? cur[k].we : 1'b0;
            be[k]    = req[k] ? cur[k].be : 4'h0;
            addr[k]  = req[k] ? cur[k].addr : 32'h0;
            wdata[k] = req[k] ? cur[k].wdata : 32'h0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (busy() && n < limit) begin cycle(); n++; end
        check("drain_timeout", busy(), 1'b0);
    endtask

    initial begin
        int          start;
        logic [31:0] v;
        int          r;
        rst_n = 1'b0; req = '0; we = '0;
        for (int k = 0; k < NI; k++) begin be[k] = 4'h0; addr[k] = '0; wdata[k] = '0; end
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst_n = 1'b1;

        for (int k = 0; k < NI; k++)
            for (int i = 0; i < DEP; i++) begin
                v = $urandom(); init_w[k][i] = v;
                push(k, K_TXN, 1'b1, 4'hF, base_m[k] + 32'(4 * i), v);
            end
        drain(2000);

        // Config 0: same-cycle grant, single-cycle response, byte lanes, range error
        clear_logs(0); start = cyc;
        push(0, K_TXN, 1'b1, 4'hF,    32'h10, 32'hDEADBEEF);
        push(0, K_TXN, 1'b1, 4'hF,    32'h20, 32'hFFFFFFFF);
        push(0, K_TXN, 1'b1, 4'b0101, 32'h20, 32'h11223344);
        push(0, K_TXN, 1'b0, 4'h0,    32'h10, 32'h0);
        push(0, K_TXN, 1'b0, 4'hF,    32'h20, 32'h0);
        push(0, K_TXN, 1'b0, 4'hF,    BASE0 + DEP * 4, 32'h0);
        push(0, K_TXN, 1'b1, 4'hF,    BASE0 + DEP * 4, 32'h1);
        push(0, K_TXN, 1'b0, 4'hF,    32'h0, 32'h0);
        drain(200);
        check("c0_first_gnt", gnt_log[0][0], start);
        check("c0_read_gnt", gnt_log[0][3], start + 3);
        check("c0_read_rvalid", rv_log[0][3], start + 4);
        check("c0_raw_data", rsp_data[0][3], 32'hDEADBEEF);
        check("c0_raw_err", rsp_err[0][3], 1'b0);
        check("c0_be_merge", rsp_data[0][4], 32'hFF22FF44);
        check("c0_oor_err", rsp_err[0][5], 1'b1);
        check("c0_oor_data", rsp_data[0][5], 32'h0);
        check("c0_oor_wr_err", rsp_err[0][6], 1'b1);
        check("c0_word0_kept", rsp_data[0][7], init_w[0][0]);

        // Config 1: grant delay 2, aborted request, address below base
        clear_logs(1); start = cyc;
        push(1, K_TXN,   1'b0, 4'hF, 32'h1000, 32'h0);
        push(1, K_TXN,   1'b0, 4'hF, 32'h1004, 32'h0);
        push(1, K_IDLE,  1'b0, 4'h0, 32'h0,    32'h0);
        push(1, K_ABORT, 1'b1, 4'hF, 32'h1008, 32'h12345678);
        push(1, K_IDLE,  1'b0, 4'h0, 32'h0,    32'h0);
        push(1, K_TXN,   1'b0, 4'hF, 32'h1008, 32'h0);
        push(1, K_TXN,   1'b0, 4'hF, 32'h0FFC, 32'h0);
        drain(200);
        check("c1_gnt_a", gnt_log[1][0], start + 2);
        check("c1_gnt_b", gnt_log[1][1], start + 5);
        check("c1_rv_a", rv_log[1][0], start + 4);
        check("c1_rv_b", rv_log[1][1], start + 7);
        check("c1_gnt_count", gnt_log[1].size(), 4);
        check("c1_data_a", rsp_data[1][0], init_w[1][0]);
        check("c1_data_b", rsp_data[1][1], init_w[1][1]);
        check("c1_abort_nowrite", rsp_data[1][2], init_w[1][2]);
        check("c1_below_base_err", rsp_err[1][3], 1'b1);

        // Config 2: outstanding limit with 4-cycle response
        clear_logs(2); start = cyc;
        push(2, K_TXN, 1'b0, 4'hF, 32'h0, 32'h0);
        push(2, K_TXN, 1'b0, 4'hF, 32'h4, 32'h0);
        push(2, K_TXN, 1'b0, 4'hF, 32'h8, 32'h0);
        drain(200);
        check("c2_gnt0", gnt_log[2][0], start);
        check("c2_gnt1", gnt_log[2][1], start + 1);
        check("c2_gnt2", gnt_log[2][2], start + 5);
        check("c2_rv0", rv_log[2][0], start + 4);
        check("c2_rv1", rv_log[2][1], start + 5);
        check("c2_rv2", rv_log[2][2], start + 9);
        check("c2_order0", rsp_data[2][0], init_w[2][0]);
        check("c2_order2", rsp_data[2][2], init_w[2][2]);

        // Reset with two reads in flight; granted write before reset must persist
        clear_logs(0); clear_logs(2);
        push(2, K_TXN, 1'b0, 4'hF, 32'h0C, 32'h0);
        push(2, K_TXN, 1'b0, 4'hF, 32'h10, 32'h0);
        push(2, K_TXN, 1'b0, 4'hF, 32'h14, 32'h0);
        push(0, K_TXN, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
        repeat (3) push(0, K_IDLE, 1'b0, 4'h0, 32'h0, 32'h0);
        push(0, K_TXN, 1'b0, 4'hF, 32'h30, 32'h0);
        cycle(); cycle();
        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        drain(200);
        check("rst_rv_count", rv_log[2].size(), 1);
        check("rst_new_read", rsp_data[2][0], init_w[2][5]);
        check("rst_write_kept", rsp_data[0][rsp_data[0].size() - 1], 32'hCAFEF00D);

        // Randomized traffic on all three configurations
        for (int n = 0; n < 150; n++)
            for (int k = 0; k < NI; k++) begin
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    push(k, K_IDLE, 1'b0, 4'h0, 32'h0, 32'h0);
                end else if (r == 9 && k == 1) begin
                    push(k, K_ABORT, 1'b1, 4'hF, base_m[k] + 32'(4 * $urandom_range(0, DEP - 1)), $urandom());
                    push(k, K_IDLE, 1'b0, 4'h0, 32'h0, 32'h0);
                end else begin
                    if ($urandom_range(0, 9) == 0)
                        v = (k == 1 && $urandom_range(0, 1) == 1) ? base_m[k] - 32'(4 * $urandom_range(1, 8))
                                                                  : base_m[k] + 32'(4 * (DEP + $urandom_range(0, 15)));
                    else
                        v = base_m[k] + 32'(4 * $urandom_range(0, DEP - 1)) + 32'($urandom_range(0, 3));
                    push(k, K_TXN, 1'($urandom_range(0, 1)), 4'($urandom()), v, $urandom());
                end
            end
        drain(5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
